// File: rtl/fixed_silu_pkg.sv
// Shared widths, LUT sizing helper and round-robin pointer type for the
// fixed-point SiLU lookup datapath.
package fixed_silu_pkg;

  localparam int DEF_DATA_IN_W     = 8;
  localparam int DEF_DATA_IN_FRAC  = 4;
  localparam int DEF_DATA_OUT_W    = 8;
  localparam int DEF_DATA_OUT_FRAC = 4;
  localparam int DEF_NUM_REQ       = 4;

  typedef logic [$clog2(DEF_NUM_REQ)-1:0] rr_ptr_t;

  function automatic int lut_depth(input int w);
    return 2 ** w;
  endfunction

endpackage

// File: rtl/fixed_silu_lut_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first active request after ptr_i, wrapping
// modulo NUM_REQ. Purely combinational; the caller owns the pointer register.
module rr_arbiter
  import fixed_silu_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o,
  output logic               gnt_vld_o
);

  logic [ID_W-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr_i) + k) % NUM_REQ);
      if (en_i && !gnt_vld_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
        gnt_vld_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fixed_silu_lut_arbiter.sv
// Runtime-programmable SiLU LUT shared by NUM_REQ streams: round-robin issue,
// synchronous LUT read (s1), output register (s2) with backpressure.
module fixed_silu_lut_arbiter
  import fixed_silu_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0  = DEF_DATA_IN_W,
  parameter int DATA_IN_0_PRECISION_1  = DEF_DATA_IN_FRAC,
  parameter int DATA_OUT_0_PRECISION_0 = DEF_DATA_OUT_W,
  parameter int DATA_OUT_0_PRECISION_1 = DEF_DATA_OUT_FRAC,
  parameter int NUM_REQ                = DEF_NUM_REQ,
  parameter int ID_W                   = $clog2(NUM_REQ)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_REQ*DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic [NUM_REQ-1:0]                        data_in_0_valid,
  output logic [NUM_REQ-1:0]                        data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0]         data_out_0,
  output logic [ID_W-1:0]                           data_out_0_id,
  output logic                                      data_out_0_valid,
  input  logic                                      data_out_0_ready,
  input  logic                                      cfg_we,
  input  logic [DATA_IN_0_PRECISION_0-1:0]          cfg_addr,
  input  logic [DATA_OUT_0_PRECISION_0-1:0]         cfg_data,
  output logic                                      busy
);

  localparam int AW    = DATA_IN_0_PRECISION_0;
  localparam int OW    = DATA_OUT_0_PRECISION_0;
  localparam int DEPTH = lut_depth(AW);

  if (DATA_IN_0_PRECISION_1 > AW || DATA_OUT_0_PRECISION_1 > OW || NUM_REQ < 2) begin : g_param_check
    $error("fixed_silu_lut_arbiter: inconsistent parameters");
  end

  logic [OW-1:0]   lut_q [DEPTH];

  logic            s1_vld_q, s1_vld_d;
  logic [OW-1:0]   s1_data_q, s1_data_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  logic            out_vld_q, out_vld_d;
  logic [OW-1:0]   out_data_q, out_data_d;
  logic [ID_W-1:0] out_id_q, out_id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  logic            adv2, can_issue, gnt_vld;
  logic [ID_W-1:0] gnt_idx;
  logic [AW-1:0]   rd_addr;

  assign adv2      = !out_vld_q | data_out_0_ready;
  // Gating with rst keeps readies low while the block is held in reset.
  assign can_issue = (!s1_vld_q | adv2) & !cfg_we & rst;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i     (data_in_0_valid),
    .en_i      (can_issue),
    .ptr_i     (ptr_q),
    .gnt_o     (data_in_0_ready),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    rd_addr = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (data_in_0_ready[r]) rd_addr = data_in_0[r*AW +: AW];
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_we) lut_q[cfg_addr] <= cfg_data;
  end

  always_comb begin
    s1_vld_d   = s1_vld_q;
    s1_data_d  = s1_data_q;
    s1_id_d    = s1_id_q;
    ptr_d      = ptr_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    if (gnt_vld) begin
      s1_vld_d  = 1'b1;
      s1_data_d = lut_q[rd_addr];
      s1_id_d   = gnt_idx;
      ptr_d     = gnt_idx;
    end else if (adv2) begin
      s1_vld_d  = 1'b0;
    end
    if (adv2) begin
      out_vld_d  = s1_vld_q;
      out_data_d = s1_data_q;
      out_id_d   = s1_id_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q   <= 1'b0;
      s1_data_q  <= '0;
      s1_id_q    <= '0;
      ptr_q      <= ID_W'(NUM_REQ - 1);
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_id_q   <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_data_q  <= s1_data_d;
      s1_id_q    <= s1_id_d;
      ptr_q      <= ptr_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
    end
  end

  assign data_out_0       = out_data_q;
  assign data_out_0_id    = out_id_q;
  assign data_out_0_valid = out_vld_q;
  assign busy             = s1_vld_q | out_vld_q;

endmodule
